// File: rtl/sort_iter_ctrl_if.sv
// Handshake bundle between the bitonic sequencer, the host
// start/done side and the compare-exchange datapath.
interface sort_iter_ctrl_if #(
    parameter int KW = 4,
    parameter int SW = 6
);
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          load_en;
    logic          stage_valid;
    logic          stage_ready;
    logic [KW-1:0] stage_k;
    logic [KW-1:0] stage_j;
    logic          stage_dir;
    logic          stage_last;
    logic          stage_ack;
    logic [SW-1:0] stage_idx;

    modport master (
        input  start,
        input  abort,
        input  stage_ready,
        input  stage_ack,
        output busy,
        output done,
        output load_en,
        output stage_valid,
        output stage_k,
        output stage_j,
        output stage_dir,
        output stage_last,
        output stage_idx
    );

    modport slave (
        output start,
        output abort,
        output stage_ready,
        output stage_ack,
        input  busy,
        input  done,
        input  load_en,
        input  stage_valid,
        input  stage_k,
        input  stage_j,
        input  stage_dir,
        input  stage_last,
        input  stage_idx
    );
endinterface

// File: rtl/sort_iter_ctrl.sv
// Bitonic schedule sequencer: walks (k, j) over every
// compare-exchange pass and hands each one to the datapath.
module sort_iter_ctrl #(
    parameter int DATA_CNT  = 1024,
    parameter int LOG_CNT   = 10,
    parameter     COM_STYLE = "UP",
    parameter int KW        = 4,
    parameter int SW        = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    sort_iter_ctrl_if.master bus
);

    if (DATA_CNT != (1 << LOG_CNT)) begin : g_bad_cnt
        $error("DATA_CNT must equal 2**LOG_CNT");
    end

    localparam logic [KW-1:0] K_MAX = KW'(LOG_CNT);
    localparam logic [KW-1:0] K_ONE = KW'(1);
    localparam logic          DIR   = (COM_STYLE == "UP");

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    logic          busy_q;
    logic          done_q;
    logic          load_q;
    logic          valid_q;
    logic          last_q;
    logic [KW-1:0] k_q;
    logic [KW-1:0] j_q;
    logic [SW-1:0] idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            k_q     <= K_ONE;
            j_q     <= '0;
            idx_q   <= '0;
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            // abort outranks every handshake once a sort is running
            if (bus.abort && state != S_IDLE) begin
                state   <= S_IDLE;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            state  <= S_LOAD;
                            busy_q <= 1'b1;
                            load_q <= 1'b1;
                            k_q    <= K_ONE;
                            j_q    <= '0;
                            idx_q  <= '0;
                            last_q <= (K_MAX == K_ONE);
                        end
                    end
                    S_LOAD: begin
                        state   <= S_ISSUE;
                        valid_q <= 1'b1;
                    end
                    S_ISSUE: begin
                        if (bus.stage_ready) begin
                            state   <= S_WAIT;
                            valid_q <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (bus.stage_ack) begin
                            if (j_q != '0) begin
                                state   <= S_ISSUE;
                                valid_q <= 1'b1;
                                j_q     <= j_q - K_ONE;
                                idx_q   <= idx_q + SW'(1);
                                last_q  <= (k_q == K_MAX)
                                        && (j_q == K_ONE);
                            end else if (k_q != K_MAX) begin
                                // new block: j restarts at new_k-1 = old k
                                state   <= S_ISSUE;
                                valid_q <= 1'b1;
                                k_q     <= k_q + K_ONE;
                                j_q     <= k_q;
                                idx_q   <= idx_q + SW'(1);
                                last_q  <= 1'b0;
                            end else begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.load_en     = load_q;
    assign bus.stage_valid = valid_q;
    assign bus.stage_k     = k_q;
    assign bus.stage_j     = j_q;
    assign bus.stage_dir   = DIR;
    assign bus.stage_last  = last_q;
    assign bus.stage_idx   = idx_q;

endmodule
